// File: rtl/srrc_fir_sym_prog.sv
// Symmetric-coefficient pipelined FIR for SRRC pulse shaping / matched filtering.
// Pre-add, multiply, sum and round/saturate stages; double-buffered coefficient bank.
module srrc_fir_sym_prog #(
  parameter int unsigned DW        = 18,
  parameter int unsigned CW        = 18,
  parameter int unsigned NTAPS     = 17,
  parameter int unsigned OUT_SHIFT = 17,
  localparam int unsigned M        = (NTAPS + 1) / 2,
  localparam int unsigned AW       = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sam_clk,
  input  logic signed [DW-1:0] in,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic                 swap_pending,
  output logic signed [DW-1:0] out,
  output logic                 out_valid,
  output logic                 sat_flag
);

  localparam int unsigned PW = DW + 1;
  localparam int unsigned MW = PW + CW;
  localparam int unsigned SW = MW + $clog2(M);
  localparam int unsigned RW = SW + 1;

  localparam logic signed [RW-1:0] Half = RW'(64'd1 << (OUT_SHIFT - 1));
  localparam logic signed [RW-1:0] MaxV = RW'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic signed [RW-1:0] MinV = ~MaxV;

  logic signed [DW-1:0] x_q      [NTAPS];
  logic signed [DW-1:0] x_d      [NTAPS];
  logic signed [PW-1:0] p_q      [M];
  logic signed [PW-1:0] p_d      [M];
  logic signed [MW-1:0] m_q      [M];
  logic signed [MW-1:0] m_d      [M];
  logic signed [CW-1:0] shadow_q [M];
  logic signed [CW-1:0] shadow_d [M];
  logic signed [CW-1:0] act_q    [M];
  logic signed [SW-1:0] s_q, s_d;
  logic signed [RW-1:0] rnd, r;
  logic signed [DW-1:0] out_q, out_d;
  logic                 sat_q, sat_d;
  logic                 v1_q, v2_q, v3_q, out_valid_q;
  logic                 swap_pending_q, swap_pending_d, do_swap;

  // Stage 1 sees the delay line as it will be after this edge's shift.
  always_comb begin
    x_d[0] = in;
    for (int k = 1; k < NTAPS; k++) begin
      x_d[k] = x_q[k-1];
    end
    for (int k = 0; k < M - 1; k++) begin
      p_d[k] = PW'(x_d[k]) + PW'(x_d[NTAPS-1-k]);
    end
    p_d[M-1] = PW'(x_d[M-1]);
  end

  always_comb begin
    for (int k = 0; k < M; k++) begin
      m_d[k] = MW'(p_q[k]) * MW'(act_q[k]);
    end
  end

  always_comb begin
    s_d = '0;
    for (int k = 0; k < M; k++) begin
      s_d = s_d + SW'(m_q[k]);
    end
  end

  assign rnd = RW'(s_q) + Half;
  assign r   = rnd >>> OUT_SHIFT;

  always_comb begin
    out_d = r[DW-1:0];
    sat_d = 1'b0;
    if (r > MaxV) begin
      out_d = MaxV[DW-1:0];
      sat_d = 1'b1;
    end else if (r < MinV) begin
      out_d = MinV[DW-1:0];
      sat_d = 1'b1;
    end
  end

  // Write lands in shadow_d first so a same-edge copy picks it up.
  always_comb begin
    shadow_d = shadow_q;
    if (coef_we && (32'(coef_addr) < M)) begin
      shadow_d[coef_addr] = coef_data;
    end
    do_swap        = sam_clk && (swap_pending_q || coef_swap);
    swap_pending_d = !do_swap && (swap_pending_q || coef_swap);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q            <= '{default: '0};
      p_q            <= '{default: '0};
      m_q            <= '{default: '0};
      shadow_q       <= '{default: '0};
      act_q          <= '{default: '0};
      s_q            <= '0;
      out_q          <= '0;
      sat_q          <= 1'b0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      v3_q           <= 1'b0;
      out_valid_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      if (sam_clk) begin
        x_q <= x_d;
        p_q <= p_d;
      end
      m_q         <= m_d;
      s_q         <= s_d;
      v1_q        <= sam_clk;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      if (v3_q) begin
        out_q <= out_d;
        sat_q <= sat_d;
      end
      shadow_q <= shadow_d;
      if (do_swap) begin
        act_q <= shadow_d;
      end
      swap_pending_q <= swap_pending_d;
    end
  end

  assign out          = out_q;
  assign sat_flag     = sat_q;
  assign out_valid    = out_valid_q;
  assign swap_pending = swap_pending_q;

endmodule

// File: tb/tb_srrc_fir_sym_prog.sv
// Scoreboard bench for srrc_fir_sym_prog: direct-convolution reference model,
// expected results queued at stimulus time and popped by an independent monitor.
module tb_srrc_fir_sym_prog;

  localparam int DW    = 18;
  localparam int CW    = 18;
  localparam int NTAPS = 17;
  localparam int M     = 9;
  localparam int AW    = 4;
  localparam int OS    = 17;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sam_clk;
  logic signed [DW-1:0] din;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_swap;
  logic                 swap_pending;
  logic signed [DW-1:0] dout;
  logic                 out_valid;
  logic                 sat_flag;

  srrc_fir_sym_prog #(
    .DW       (DW),
    .CW       (CW),
    .NTAPS    (NTAPS),
    .OUT_SHIFT(OS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sam_clk     (sam_clk),
    .in          (din),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_swap   (coef_swap),
    .swap_pending(swap_pending),
    .out         (dout),
    .out_valid   (out_valid),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit sat;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   got_q[$];
  bit   gotsat_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model state: sample history (newest first) and the two banks.
  int hist[NTAPS];
  int sh[M];
  int act[M];
  bit pend;
  int bank[M];

  int imp_c[M] = '{3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65624};
  int imp_exp[NTAPS] = '{3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65623,
                         57937, 38196, 14611, -3946, -12207, -10461, -3378, 3259};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint actual, longint required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid) begin
      got_q.push_back(int'(dout));
      gotsat_q.push_back(sat_flag);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected out_valid: got strobe with out=%0d, required no strobe", dout);
      end else begin
        e = exp_q.pop_front();
        check("out value", dout, e.val);
        check("sat_flag", sat_flag, e.sat);
        check("strobe cycle", cyc, e.cyc);
      end
    end
  end

  function automatic int rnd_s(int w);
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction

  // y[n] = round_half_up(sum h[k]*x[n-k] / 2^OS), clipped to DW bits.
  task automatic push_expected();
    longint acc = 0;
    longint r;
    exp_t   e;
    for (int k = 0; k < NTAPS; k++) begin
      acc += longint'(hist[k]) * longint'(act[(k < M) ? k : NTAPS - 1 - k]);
    end
    r = (acc + (longint'(1) <<< (OS - 1))) >>> OS;
    e.sat = 1'b1;
    if (r > 131071) e.val = 131071;
    else if (r < -131072) e.val = -131072;
    else begin
      e.val = int'(r);
      e.sat = 1'b0;
    end
    e.cyc = cyc + 4;
    exp_q.push_back(e);
  endtask

  task automatic step(bit sc, int d, bit we = 0, int a = 0, int cd = 0, bit sw = 0);
    sam_clk   = sc;
    din       = DW'(d);
    coef_we   = we;
    coef_addr = AW'(a);
    coef_data = CW'(cd);
    coef_swap = sw;
    if (we && a < M) sh[a] = cd;
    if (sw) pend = 1'b1;
    if (sc) begin
      if (pend) begin
        act  = sh;
        pend = 1'b0;
      end
      for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      push_expected();
    end
    @(posedge clk);
    #1;
    check("swap_pending", swap_pending, pend);
  endtask

  task automatic do_reset(bit busy);
    reset     = 1'b0;
    sam_clk   = busy;
    din       = DW'(rnd_s(DW));
    coef_we   = busy;
    coef_addr = '0;
    coef_data = CW'(rnd_s(CW));
    coef_swap = busy;
    @(posedge clk);
    #1;
    for (int k = 0; k < NTAPS; k++) hist[k] = 0;
    for (int k = 0; k < M; k++) begin
      sh[k]  = 0;
      act[k] = 0;
    end
    pend = 1'b0;
    exp_q.delete();
    check("reset out", dout, 0);
    check("reset out_valid", out_valid, 0);
    check("reset sat_flag", sat_flag, 0);
    check("reset swap_pending", swap_pending, 0);
    reset = 1'b1;
  endtask

  task automatic load_bank();
    for (int i = 0; i < M; i++) step(0, 0, 1, i, bank[i]);
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  initial begin
    do_reset(0);

    // Impulse response, one sample every 4th cycle.
    bank = imp_c;
    load_bank();
    got_q.delete();
    gotsat_q.delete();
    for (int s = 0; s < 20; s++) begin
      step(1, (s == 0) ? 131071 : 0);
      drain(3);
    end
    drain(4);
    check("impulse count", got_q.size(), 20);
    if (got_q.size() >= NTAPS) begin
      for (int i = 0; i < NTAPS; i++) begin
        check("impulse tap", got_q[i], imp_exp[i]);
        check("impulse sat", gotsat_q[i], 0);
      end
    end

    // Positive and negative saturation.
    for (int i = 0; i < M; i++) bank[i] = 131071;
    load_bank();
    got_q.delete();
    gotsat_q.delete();
    for (int s = 0; s < 20; s++) step(1, 131071);
    drain(5);
    check("pos sat count", got_q.size(), 20);
    if (got_q.size() > 0) begin
      check("pos sat value", got_q[$], 131071);
      check("pos sat flag", gotsat_q[$], 1);
    end
    got_q.delete();
    gotsat_q.delete();
    for (int s = 0; s < 20; s++) step(1, -131072);
    drain(5);
    if (got_q.size() > 0) begin
      check("neg sat value", got_q[$], -131072);
      check("neg sat flag", gotsat_q[$], 1);
    end

    // Back-to-back random stream.
    for (int i = 0; i < M; i++) bank[i] = rnd_s(CW);
    load_bank();
    got_q.delete();
    for (int s = 0; s < 40; s++) step(1, rnd_s(DW));
    drain(5);
    check("b2b strobes", got_q.size(), 40);

    // Atomic swap: centre-only bank, then rewrite shadow while streaming.
    for (int i = 0; i < M; i++) bank[i] = (i == M - 1) ? 65536 : 0;
    load_bank();
    for (int s = 0; s < 10; s++) begin
      step(1, rnd_s(DW));
      step(0, 0);
    end
    for (int i = 0; i < M; i++) begin
      step(1, rnd_s(DW));
      step(0, 0, 1, i, rnd_s(CW));
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0);
    for (int s = 0; s < 20; s++) begin
      step(1, rnd_s(DW));
      step(0, 0);
    end

    // Write/copy collision on the centre tap, then an ignored write to address M.
    step(0, 0, 0, 0, 0, 1);
    step(1, rnd_s(DW), 1, M - 1, rnd_s(CW));
    for (int s = 0; s < 20; s++) step(1, rnd_s(DW));
    step(0, 0, 1, M, 12345);
    step(0, 0, 0, 0, 0, 1);
    for (int s = 0; s < 20; s++) step(1, rnd_s(DW));

    // Reset mid-stream: in-flight samples vanish, banks return to zero.
    for (int s = 0; s < 6; s++) step(1, rnd_s(DW));
    do_reset(1);
    got_q.delete();
    for (int s = 0; s < 10; s++) step(1, rnd_s(DW));
    drain(6);
    check("post-reset strobes", got_q.size(), 10);

    check("scoreboard empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
